// File: rtl/twi_gen.sv
// Goldilocks (p = 2^64-2^32+1) twiddle generator: produces omega^0..omega^15 mod p, one lane per cycle.
// Optional TWIGEN_OUTREG_EN adds one register stage on twi_o/BN_out/MA_out/done.
`timescale 1ns/1ps
module twi_gen #(
  parameter int P_WIDTH = 64,
  parameter int A_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [P_WIDTH-1:0]     omega,
  input  logic                   BN_in,
  input  logic [A_WIDTH-1:0]     MA_in,
  output logic                   busy,
  output logic                   done,
  output logic                   BN_out,
  output logic [A_WIDTH-1:0]     MA_out,
  output logic [16*P_WIDTH-1:0]  twi_o
);

  localparam logic [63:0] PRIME = 64'hFFFFFFFF00000001;
  localparam int HW = P_WIDTH / 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           k_q, k_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d, w_q, w_d;
  logic [P_WIDTH-1:0]   lane_q [16];
  logic [P_WIDTH-1:0]   lane_d [16];
  logic                 bn_q, bn_d;
  logic [A_WIDTH-1:0]   ma_q, ma_d;
  logic [P_WIDTH-1:0]   mul_r;
  logic [16*P_WIDTH-1:0] twi_c;
  logic                 done_c;

  // 2^64 == 2^32-1 and 2^96 == -1 (mod p); +p keeps the sum non-negative, a second fold
  // brings it below 2p, so a single conditional subtract yields the canonical value.
  function automatic logic [P_WIDTH-1:0] modmul(input logic [P_WIDTH-1:0] a,
                                                input logic [P_WIDTH-1:0] b);
    logic [2*P_WIDTH-1:0] prod;
    logic [P_WIDTH-1:0]   lo, mid, f;
    logic [HW-1:0]        hl, hh, vh;
    logic [P_WIDTH+1:0]   v;
    logic [P_WIDTH:0]     v2, d;
    prod = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
    lo   = prod[P_WIDTH-1:0];
    hl   = prod[P_WIDTH+HW-1:P_WIDTH];
    hh   = prod[2*P_WIDTH-1:P_WIDTH+HW];
    mid  = {hl, {HW{1'b0}}} - {{HW{1'b0}}, hl};
    v    = {2'b00, lo} + {2'b00, mid} + {2'b00, PRIME} - {{(HW+2){1'b0}}, hh};
    vh   = {{(HW-2){1'b0}}, v[P_WIDTH+1:P_WIDTH]};
    f    = {vh, {HW{1'b0}}} - {{HW{1'b0}}, vh};
    v2   = {1'b0, v[P_WIDTH-1:0]} + {1'b0, f};
    d    = v2 - {1'b0, PRIME};
    return (v2 >= {1'b0, PRIME}) ? d[P_WIDTH-1:0] : v2[P_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (k_q == 4'd15) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done_c = (state_q == S_DONE);
  end

  assign mul_r = modmul(acc_q, w_q);

  always_comb begin
    w_d    = w_q;
    acc_d  = acc_q;
    k_d    = k_q;
    bn_d   = bn_q;
    ma_d   = ma_q;
    lane_d = lane_q;
    if (state_q == S_IDLE && start) begin
      w_d       = (omega >= PRIME) ? (omega - PRIME) : omega;
      bn_d      = BN_in;
      ma_d      = MA_in;
      lane_d[0] = {{(P_WIDTH-1){1'b0}}, 1'b1};
      acc_d     = {{(P_WIDTH-1){1'b0}}, 1'b1};
      k_d       = 4'd1;
    end else if (state_q == S_MUL) begin
      acc_d       = mul_r;
      lane_d[k_q] = mul_r;
      k_d         = k_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      acc_q <= '0;
      k_q   <= '0;
      bn_q  <= 1'b0;
      ma_q  <= '0;
      for (int i = 0; i < 16; i++) lane_q[i] <= '0;
    end else begin
      w_q    <= w_d;
      acc_q  <= acc_d;
      k_q    <= k_d;
      bn_q   <= bn_d;
      ma_q   <= ma_d;
      lane_q <= lane_d;
    end
  end

  always_comb begin
    twi_c = '0;
    for (int i = 0; i < 16; i++) twi_c[i*P_WIDTH +: P_WIDTH] = lane_q[i];
  end

`ifdef TWIGEN_OUTREG_EN
  logic [16*P_WIDTH-1:0] twi_oq;
  logic                  done_oq, bn_oq;
  logic [A_WIDTH-1:0]    ma_oq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      twi_oq  <= '0;
      done_oq <= 1'b0;
      bn_oq   <= 1'b0;
      ma_oq   <= '0;
    end else begin
      twi_oq  <= twi_c;
      done_oq <= done_c;
      bn_oq   <= bn_q;
      ma_oq   <= ma_q;
    end
  end

  assign twi_o  = twi_oq;
  assign done   = done_oq;
  assign BN_out = bn_oq;
  assign MA_out = ma_oq;
`else
  assign twi_o  = twi_c;
  assign done   = done_c;
  assign BN_out = bn_q;
  assign MA_out = ma_q;
`endif

endmodule

// File: tb/tb_twi_gen.sv
// Randomized bench for twi_gen against a modular-exponentiation reference model.
`timescale 1ns/1ps
module tb_twi_gen;

  localparam logic [63:0] P = 64'hFFFFFFFF00000001;
`ifdef TWIGEN_OUTREG_EN
  localparam int EXP_EDGES = 16;
`else
  localparam int EXP_EDGES = 15;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   omega = '0;
  logic          BN_in = 1'b0;
  logic [10:0]   MA_in = '0;
  logic          busy, done, BN_out;
  logic [10:0]   MA_out;
  logic [1023:0] twi_o;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_l [16];

  always #5 clk = ~clk;

  twi_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .omega(omega),
    .BN_in(BN_in), .MA_in(MA_in), .busy(busy), .done(done),
    .BN_out(BN_out), .MA_out(MA_out), .twi_o(twi_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] lane(input int k);
    return twi_o[k*64 +: 64];
  endfunction

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] x;
    x = ({64'd0, a} * {64'd0, b}) % {64'd0, P};
    return x[63:0];
  endfunction

  // Reference: lane k = omega^k mod p by repeated modular multiplication.
  task automatic fill_model(input logic [63:0] om);
    logic [63:0] w;
    w = om % P;
    exp_l[0] = 64'd1;
    for (int k = 1; k < 16; k++) exp_l[k] = mulmod(exp_l[k-1], w);
  endtask

  task automatic scramble();
    omega = rand64();
    BN_in = 1'($urandom());
    MA_in = 11'($urandom());
  endtask

  task automatic wait_done(input bit interfere, output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      scramble();
      start = interfere && (edges == 5);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic run_set(input logic [63:0] om, input logic bn, input logic [10:0] ma,
                         input bit interfere);
    int edges;
    @(negedge clk);
    start = 1'b1; omega = om; BN_in = bn; MA_in = ma;
    @(negedge clk);
    start = 1'b0;
    scramble();
    check("busy_run", 64'(busy), 64'd1);
    wait_done(interfere, edges);
    check("latency", 64'(edges), 64'(EXP_EDGES));
    check("done_hi", 64'(done), 64'd1);
`ifndef TWIGEN_OUTREG_EN
    check("busy_at_done", 64'(busy), 64'd1);
`endif
    fill_model(om);
    for (int k = 0; k < 16; k++) check($sformatf("lane%0d", k), lane(k), exp_l[k]);
    check("bn_out", 64'(BN_out), 64'(bn));
    check("ma_out", 64'(MA_out), 64'(ma));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    repeat (3) begin
      scramble();
      @(negedge clk);
    end
    check("hold_lane15", lane(15), exp_l[15]);
    check("hold_ma", 64'(MA_out), 64'(ma));
  endtask

  initial begin
    int seen, t, d1, d2;
    logic [63:0] om;

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_twi", 64'(|twi_o), 64'd0);
    check("rst_ma", 64'(MA_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_set(64'd2, 1'b1, 11'h5A5, 1'b0);
    check("w2_lane15", lane(15), 64'h8000);
    run_set(64'd256, 1'b0, 11'h011, 1'b0);
    check("w256_lane12", lane(12), 64'hFFFFFFFF00000000);
    check("w256_lane13", lane(13), 64'hFFFFFFFEFFFFFF01);
    run_set(P - 64'd1, 1'b1, 11'h123, 1'b0);
    check("pm1_lane7", lane(7), P - 64'd1);
    run_set(P, 1'b0, 11'h7FF, 1'b0);
    check("p_lane1", lane(1), 64'd0);
    run_set(64'd0, 1'b1, 11'h000, 1'b0);
    run_set(64'hFFFFFFFFFFFFFFFF, 1'b0, 11'h3C3, 1'b0);

    // second start mid-run must be ignored
    run_set(64'd3, 1'b1, 11'h0AA, 1'b1);

    for (int i = 0; i < 8; i++) begin
      om = (i % 3 == 0) ? P + 64'($urandom_range(0, 5)) : rand64();
      run_set(om, 1'(i), 11'($urandom()), 1'b0);
    end

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; omega = 64'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_twi", 64'(|twi_o), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_bn", 64'(BN_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    run_set(64'd7, 1'b1, 11'h155, 1'b0);

    // start held high: one set every 17 cycles
    @(negedge clk);
    start = 1'b1; omega = 64'd2; BN_in = 1'b0; MA_in = 11'h007;
    t = 0; d1 = -1; d2 = -1;
    while (t < 60) begin
      @(negedge clk);
      t++;
      if (done && d1 < 0) d1 = t;
      else if (done && d2 < 0) d2 = t;
    end
    start = 1'b0;
    check("b2b_first", 64'(d1), 64'(EXP_EDGES + 1));
    check("b2b_gap", 64'(d2 - d1), 64'd17);
    repeat (40) @(negedge clk);
    run_set(64'd2, 1'b1, 11'h5A5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
